// File: rtl/mux_rr_n.sv
// N-channel registered selector with fixed-select or round-robin arbitration.
// Optional MUX_LOCK_EN adds a lock input that holds a round-robin burst on the last grantee.
module mux_rr_n #(
  parameter int bus      = 4,
  parameter int channels = 16,
  localparam int sel_w   = $clog2(channels)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [bus*channels-1:0]   d,
  input  logic [channels-1:0]       req,
  output logic [channels-1:0]       gnt,
  input  logic                      mode,
  input  logic [sel_w-1:0]          selector,
  output logic [bus-1:0]            out,
  output logic [sel_w-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
`ifdef MUX_LOCK_EN
  ,
  input  logic                      lock
`endif
);

  logic [sel_w-1:0] ptr;
  logic [sel_w-1:0] cand;
  logic [sel_w-1:0] idx;
  logic             found;
  logic             load;

  // Search starts at ptr+1 and wraps; ptr itself is visited last.
  always_comb begin
    cand  = ptr;
    found = 1'b0;
    idx   = '0;
    if (!mode) begin
      cand  = selector;
      found = req[selector];
    end else begin
`ifdef MUX_LOCK_EN
      if (lock && req[ptr]) begin
        cand  = ptr;
        found = 1'b1;
      end
`endif
      for (int i = 1; i <= channels; i++) begin
        idx = ptr + sel_w'(i);
        if (!found && req[idx]) begin
          cand  = idx;
          found = 1'b1;
        end
      end
    end
  end

  assign load = !rst && (!out_valid || out_ready) && found;

  assign gnt = load ? ({{(channels-1){1'b0}}, 1'b1} << cand)
                    : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= '0;
      out_chan  <= '0;
      out_valid <= 1'b0;
      ptr       <= sel_w'(channels - 1);
    end else if (load) begin
      out       <= d[cand*bus +: bus];
      out_chan  <= cand;
      out_valid <= 1'b1;
      ptr       <= cand;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_rr_n.sv
// Directed bench for mux_rr_n: vector table plus reset and lock sequences.
// Channel k carries data k, so out must equal out_chan after every load.
module tb_mux_rr_n;

  localparam int bus      = 4;
  localparam int channels = 16;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [bus*channels-1:0] d;
  logic [channels-1:0]     req = '0;
  logic [channels-1:0]     gnt;
  logic                    mode = 1'b0;
  logic [3:0]              selector = '0;
  logic [bus-1:0]          out;
  logic [3:0]              out_chan;
  logic                    out_valid;
  logic                    out_ready = 1'b1;
  logic                    lock = 1'b0;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  always_comb
    for (int k = 0; k < channels; k++)
      d[k*bus +: bus] = 4'(k);

  mux_rr_n #(.bus(bus), .channels(channels)) dut (
    .clk(clk),
    .rst(rst),
    .d(d),
    .req(req),
    .gnt(gnt),
    .mode(mode),
    .selector(selector),
    .out(out),
    .out_chan(out_chan),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef MUX_LOCK_EN
    ,
    .lock(lock)
`endif
  );

  typedef struct {
    logic        m;
    logic [3:0]  s;
    logic [15:0] r;
    logic        rdy;
    logic [15:0] g;
    logic        v;
    logic [3:0]  o;
    logic [3:0]  c;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic m, logic [3:0] s, logic [15:0] r,
                              logic rdy, logic [15:0] g, logic v,
                              logic [3:0] o, logic [3:0] c);
    vec_t x;
    x.m = m; x.s = s; x.r = r; x.rdy = rdy;
    x.g = g; x.v = v; x.o = o; x.c = c;
    return x;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs applied 1ns after a rising edge; gnt sampled at the falling
  // edge, registered outputs 1ns after the next rising edge.
  task automatic run(vec_t x, int n);
    mode = x.m; selector = x.s; req = x.r; out_ready = x.rdy;
    @(negedge clk);
    chk($sformatf("gnt[%0d]", n), 32'(gnt), 32'(x.g));
    @(posedge clk); #1;
    chk($sformatf("valid[%0d]", n), 32'(out_valid), 32'(x.v));
    chk($sformatf("out[%0d]", n), 32'(out), 32'(x.o));
    chk($sformatf("chan[%0d]", n), 32'(out_chan), 32'(x.c));
  endtask

  initial begin
    // fixed sweep
    for (int s = 0; s < 16; s++)
      vt.push_back(mk(0, 4'(s), 16'hFFFF, 1, 16'(1 << s), 1, 4'(s), 4'(s)));
    // fixed, selected channel idle: bubble, data retained
    vt.push_back(mk(0, 4'd5, 16'hFFDF, 1, 16'h0000, 0, 4'd15, 4'd15));
    // round-robin fairness from ptr=15
    vt.push_back(mk(1, 4'd0, 16'h8025, 1, 16'h0001, 1, 4'd0, 4'd0));
    vt.push_back(mk(1, 4'd0, 16'h8025, 1, 16'h0004, 1, 4'd2, 4'd2));
    vt.push_back(mk(1, 4'd0, 16'h8025, 1, 16'h0020, 1, 4'd5, 4'd5));
    vt.push_back(mk(1, 4'd0, 16'h8025, 1, 16'h8000, 1, 4'd15, 4'd15));
    vt.push_back(mk(1, 4'd0, 16'h8025, 1, 16'h0001, 1, 4'd0, 4'd0));
    // backpressure, ptr frozen at 0
    for (int i = 0; i < 3; i++)
      vt.push_back(mk(1, 4'd0, 16'hFFFF, 0, 16'h0000, 1, 4'd0, 4'd0));
    vt.push_back(mk(1, 4'd0, 16'hFFFF, 1, 16'h0002, 1, 4'd1, 4'd1));
    // single requester
    for (int i = 0; i < 3; i++)
      vt.push_back(mk(1, 4'd0, 16'h0200, 1, 16'h0200, 1, 4'd9, 4'd9));
    // mode switch keeps ptr
    vt.push_back(mk(0, 4'd3, 16'hFFFF, 1, 16'h0008, 1, 4'd3, 4'd3));
    vt.push_back(mk(1, 4'd3, 16'hFFFF, 1, 16'h0010, 1, 4'd4, 4'd4));
    // drain
    vt.push_back(mk(1, 4'd0, 16'h0000, 1, 16'h0000, 0, 4'd4, 4'd4));
    // empty register loads even without ready, then stalls
    vt.push_back(mk(1, 4'd0, 16'h0040, 0, 16'h0040, 1, 4'd6, 4'd6));
    vt.push_back(mk(1, 4'd0, 16'h0040, 0, 16'h0000, 1, 4'd6, 4'd6));

    // reset state
    #3;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_out", 32'(out), 32'h0);
    chk("rst_chan", 32'(out_chan), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vt[i]) run(vt[i], i);

    // async reset mid-cycle with a held word
    #2;
    rst = 1'b1;
    mode = 1'b1; req = 16'hFFFF; out_ready = 1'b1;
    #1;
    chk("mrst_valid", 32'(out_valid), 32'h0);
    chk("mrst_out", 32'(out), 32'h0);
    chk("mrst_chan", 32'(out_chan), 32'h0);
    chk("mrst_gnt", 32'(gnt), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_gnt", 32'(gnt), 32'h0001);
    @(posedge clk); #1;
    chk("post_valid", 32'(out_valid), 32'h1);
    chk("post_chan", 32'(out_chan), 32'h0);
    run(mk(1, 4'd0, 16'hFFFF, 1, 16'h0002, 1, 4'd1, 4'd1), 100);

`ifdef MUX_LOCK_EN
    // lock burst on channel 0, then release alternates 4,0,4
    @(negedge clk);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    lock = 1'b0;
    run(mk(1, 4'd0, 16'h0011, 1, 16'h0001, 1, 4'd0, 4'd0), 200);
    lock = 1'b1;
    for (int i = 0; i < 3; i++)
      run(mk(1, 4'd0, 16'h0011, 1, 16'h0001, 1, 4'd0, 4'd0), 201 + i);
    lock = 1'b0;
    run(mk(1, 4'd0, 16'h0011, 1, 16'h0010, 1, 4'd4, 4'd4), 210);
    run(mk(1, 4'd0, 16'h0011, 1, 16'h0001, 1, 4'd0, 4'd0), 211);
    run(mk(1, 4'd0, 16'h0011, 1, 16'h0010, 1, 4'd4, 4'd4), 212);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mux_rr_n.md
# mux_rr_n

Parametrised N-channel, bus-wide selector with a registered output stage and a per-channel request/grant handshake. It is the sequential successor of the core 16:1 combinational selector. It picks one requesting channel per cycle, either the channel named by `selector` (fixed mode) or by round-robin arbitration. The chosen word is captured into an output register with a valid/ready handshake. It sits in `core/selector` between multiple producers (register-file ports, ALU result sources) and a single consumer.

## Interface
Parameters:
- `bus`, 4, data width of every channel and of `out`
- `channels`, 16, number of input channels; power of two, 2..64; `sel_w = $clog2(channels)` is derived locally

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, asynchronous, active-high
- `d`  in  bus*channels  flattened channel data; channel k occupies `d[k*bus +: bus]`
- `req`  in  channels  per-channel request; a producer holds `req[k]` and its data stable until `gnt[k]`
- `gnt`  out  channels  one-hot (or zero) combinational grant; `gnt[k]` high means channel k's word is captured at this rising edge
- `mode`  in  1  0 = fixed select, 1 = round-robin
- `selector`  in  sel_w  channel index used in fixed mode
- `out`  out  bus  registered data
- `out_chan`  out  sel_w  index of the channel that produced `out`
- `out_valid`  out  1  `out`/`out_chan` hold an unconsumed word
- `out_ready`  in  1  consumer accepts the word when `out_valid && out_ready`
- `lock`  in  1  present only with `MUX_LOCK_EN`

## Operation
- State: output register (`out`, `out_chan`, `out_valid`) and round-robin pointer `ptr` (sel_w bits, index of last grant).
- `load = (!out_valid || out_ready) && cand_found`. On load: `out <= d[cand]`, `out_chan <= cand`, `out_valid <= 1`, `ptr <= cand`, `gnt = 1 << cand`.
- If `out_valid && out_ready && !cand_found`: `out_valid <= 0`; `out` and `out_chan` keep their last values.
- Fixed mode: `cand = selector`, and `cand_found = req[selector]`. Requests on other channels are ignored, with no grant.
- Round-robin mode: search `ptr+1, ptr+2, …` modulo `channels`. The first k with `req[k]` is `cand`. `ptr` itself is checked last, so a sole requester is granted every cycle.
- `ptr` updates on grants in both modes. Switching mode never resets `ptr`.
- `gnt` is all-zero whenever `load` is 0, including the case where the register is full and `out_ready = 0`.
- Out-of-range indices cannot occur because `channels` is a power of two.

## Timing
- Reset (async assert, clocked release): `out = 0`, `out_chan = 0`, `out_valid = 0`, `ptr = channels-1`, so the first round-robin search starts at channel 0. `gnt = 0` while `rst` is high.
- Latency: `req[k]` sampled high at edge n (with grant) gives `out_valid = 1` with channel k data after edge n.
- Throughput: one word per cycle while `out_ready` stays high.
- Backpressure: while `out_valid && !out_ready`, the register holds its value, `gnt = 0`, and `ptr` is frozen.
- Simultaneous consume and load in the same cycle: the new word replaces the old one, and `out_valid` stays 1 with no bubble.
- `mode`, `selector` and `req` changes take effect at the next arbitration (combinational into `gnt`, registered at the edge).
- Reset mid-transfer: the pending word is discarded, and producers must keep `req` asserted to be re-served after release.

## Configuration
- Macro: `MUX_LOCK_EN`.
- Defined: adds the `lock` input. In round-robin mode with `lock = 1`, if `req[ptr]` is high then `cand = ptr` (burst stays on the last granted channel). Otherwise the normal search applies. `lock` is ignored in fixed mode.
- Undefined: no `lock` port, and pure round-robin as described above.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle with `out_valid = 1` -> `out = 0`, `out_valid = 0`, `gnt = 0` immediately. After release, `req = 16'hFFFF`, `mode = 1` -> first grant is channel 0.
- Fixed mode: `channels = 16`, `bus = 4`, `d[k] = k`, `req = 16'hFFFF`, `out_ready = 1`, sweep `selector` 0..15 -> `out = selector` and `out_chan = selector` one cycle later. With `req[5] = 0` and `selector = 5` -> `gnt = 0`, and `out_valid` drops.
- Round-robin fairness: `req = 16'b1000_0000_0010_0101`, `out_ready = 1` -> grant order 0, 2, 5, 15, 0, … with one word per cycle.
- Backpressure: `out_ready = 0` for 3 cycles with all requesting -> `out` stable, `gnt = 0`, `ptr` frozen. On release, the next grant follows the frozen `ptr`.
- Lock (`MUX_LOCK_EN`): `req = 16'h0011`, `mode = 1`, `lock = 1` after the first grant to channel 0 -> channel 0 granted every cycle. `lock = 0` -> alternates 4, 0, 4.
- Single requester: only `req[9] = 1` in round-robin mode -> `gnt[9]` every cycle and `out_chan = 9`.
